shot_arbiter: RTL and testbench

//  Sequences every shot on the 5x5 boards. Arbitrates between player-shot and PC-shot

---
 rtl/shot_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_shot_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shot_arbiter.sv
// Shot sequencer for the two 5x5 boards: round-robin grant between player and PC,
// read-modify-write of the target cell, sunk-boat bookkeeping and win flags.
module shot_arbiter #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int NUM_BOATS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       player_req,
  input  logic [2:0] player_row,
  input  logic [2:0] player_col,
  input  logic       pc_req,
  input  logic [2:0] pc_row,
  input  logic [2:0] pc_col,
  output logic       player_ack,
  output logic       pc_ack,
  output logic       res_hit,
  output logic       res_sunk,
  output logic       res_repeat,
  output logic       res_invalid,
  output logic       brd_sel,
  output logic [4:0] brd_addr,
  output logic       brd_re,
  input  logic [2:0] brd_rdata,
  output logic       brd_we,
  output logic [2:0] brd_wdata,
  output logic [2:0] pc_boats_left,
  output logic [2:0] player_boats_left,
  output logic       player_win,
  output logic       pc_win
);

  localparam int HW = $clog2(NUM_BOATS + 1);
  localparam logic [2:0]    ROWS_L   = 3'(ROWS);
  localparam logic [2:0]    COLS_L   = 3'(COLS);
  localparam logic [4:0]    COLS_W   = 5'(COLS);
  localparam logic [2:0]    BOATS_L  = 3'(NUM_BOATS);
  localparam logic [HW-1:0] ONE_H    = HW'(1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_WRITE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           sel_q, sel_d;         // 1: player shot at PC board
  logic           rr_last_q, rr_last_d; // 1: PC was granted last
  logic [4:0]     addr_q, addr_d;
  logic [2:0]     wdata_q, wdata_d;
  logic [HW-1:0]  id_q, id_d;
  logic           re_q, re_d, we_q, we_d;
  logic           player_ack_q, player_ack_d, pc_ack_q, pc_ack_d;
  logic           hit_q, hit_d, sunk_q, sunk_d, rep_q, rep_d, inv_q, inv_d;
  logic [2:0]     pc_bl_q, pc_bl_d, player_bl_q, player_bl_d;
  logic [HW-1:0]  hits_q [2][NUM_BOATS+1];
  logic [HW-1:0]  hits_d [2][NUM_BOATS+1];
  logic           grant_pc;
  logic [2:0]     tgt_row, tgt_col;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_last_d    = rr_last_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    re_d         = 1'b0;
    we_d         = 1'b0;
    player_ack_d = 1'b0;
    pc_ack_d     = 1'b0;
    hit_d        = 1'b0;
    sunk_d       = 1'b0;
    rep_d        = 1'b0;
    inv_d        = 1'b0;
    pc_bl_d      = pc_bl_q;
    player_bl_d  = player_bl_q;
    hits_d       = hits_q;
    grant_pc     = 1'b0;
    tgt_row      = player_row;
    tgt_col      = player_col;

    case (state_q)
      S_IDLE: begin
        if (player_req || pc_req) begin
          // On a tie, grant whoever was not served last.
          grant_pc  = pc_req && (!player_req || !rr_last_q);
          tgt_row   = grant_pc ? pc_row : player_row;
          tgt_col   = grant_pc ? pc_col : player_col;
          sel_d     = !grant_pc;
          rr_last_d = grant_pc;
          addr_d    = 5'(tgt_row) * COLS_W + 5'(tgt_col);
          if (tgt_row >= ROWS_L || tgt_col >= COLS_L || player_win || pc_win) begin
            state_d      = S_DONE;
            inv_d        = 1'b1;
            player_ack_d = !grant_pc;
            pc_ack_d     = grant_pc;
          end else begin
            state_d = S_READ;
            re_d    = 1'b1;
          end
        end
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (brd_rdata[2]) begin
          state_d      = S_DONE;
          rep_d        = 1'b1;
          player_ack_d = sel_q;
          pc_ack_d     = !sel_q;
        end else begin
          state_d = S_WRITE;
          we_d    = 1'b1;
          wdata_d = brd_rdata | 3'b100;
          id_d    = HW'(brd_rdata[1:0]);
        end
      end
      S_WRITE: begin
        state_d      = S_DONE;
        player_ack_d = sel_q;
        pc_ack_d     = !sel_q;
        if (id_q != '0) begin
          hit_d                = 1'b1;
          hits_d[sel_q][id_q]  = hits_q[sel_q][id_q] + ONE_H;
          if (hits_q[sel_q][id_q] + ONE_H == id_q) begin
            sunk_d = 1'b1;
            if (sel_q && pc_bl_q != 3'd0)          pc_bl_d     = pc_bl_q - 3'd1;
            if (!sel_q && player_bl_q != 3'd0)     player_bl_d = player_bl_q - 3'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (new_game) begin
      state_d      = S_IDLE;
      rr_last_d    = 1'b1;
      re_d         = 1'b0;
      we_d         = 1'b0;
      player_ack_d = 1'b0;
      pc_ack_d     = 1'b0;
      hit_d        = 1'b0;
      sunk_d       = 1'b0;
      rep_d        = 1'b0;
      inv_d        = 1'b0;
      pc_bl_d      = BOATS_L;
      player_bl_d  = BOATS_L;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k <= NUM_BOATS; k++)
          hits_d[b][k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      rr_last_q    <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      id_q         <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      player_ack_q <= 1'b0;
      pc_ack_q     <= 1'b0;
      hit_q        <= 1'b0;
      sunk_q       <= 1'b0;
      rep_q        <= 1'b0;
      inv_q        <= 1'b0;
      pc_bl_q      <= BOATS_L;
      player_bl_q  <= BOATS_L;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k <= NUM_BOATS; k++)
          hits_q[b][k] <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_last_q    <= rr_last_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      re_q         <= re_d;
      we_q         <= we_d;
      player_ack_q <= player_ack_d;
      pc_ack_q     <= pc_ack_d;
      hit_q        <= hit_d;
      sunk_q       <= sunk_d;
      rep_q        <= rep_d;
      inv_q        <= inv_d;
      pc_bl_q      <= pc_bl_d;
      player_bl_q  <= player_bl_d;
      hits_q       <= hits_d;
    end
  end

  // A new_game arriving during WRITE must keep the cell untouched.
  assign brd_we            = we_q & ~new_game;
  assign brd_re            = re_q;
  assign brd_sel           = sel_q;
  assign brd_addr          = addr_q;
  assign brd_wdata         = wdata_q;
  assign player_ack        = player_ack_q;
  assign pc_ack            = pc_ack_q;
  assign res_hit           = hit_q;
  assign res_sunk          = sunk_q;
  assign res_repeat        = rep_q;
  assign res_invalid       = inv_q;
  assign pc_boats_left     = pc_bl_q;
  assign player_boats_left = player_bl_q;
  assign player_win        = (pc_bl_q == 3'd0);
  assign pc_win            = (player_bl_q == 3'd0);

endmodule

// File: tb/tb_shot_arbiter.sv
// Directed bench for shot_arbiter with a simple two-board register file behind it.
module tb_shot_arbiter;
  logic       clk = 0;
  logic       rst;
  logic       new_game;
  logic       player_req, pc_req;
  logic [2:0] player_row, player_col, pc_row, pc_col;
  logic       player_ack, pc_ack, res_hit, res_sunk, res_repeat, res_invalid;
  logic       brd_sel, brd_re, brd_we;
  logic [4:0] brd_addr;
  logic [2:0] brd_rdata, brd_wdata;
  logic [2:0] pc_boats_left, player_boats_left;
  logic       player_win, pc_win;

  int total = 0;
  int bad   = 0;

  logic [2:0] mem [0:1][0:24];

  always #5 clk = ~clk;

  shot_arbiter dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .player_req(player_req), .player_row(player_row), .player_col(player_col),
    .pc_req(pc_req), .pc_row(pc_row), .pc_col(pc_col),
    .player_ack(player_ack), .pc_ack(pc_ack),
    .res_hit(res_hit), .res_sunk(res_sunk), .res_repeat(res_repeat), .res_invalid(res_invalid),
    .brd_sel(brd_sel), .brd_addr(brd_addr), .brd_re(brd_re), .brd_rdata(brd_rdata),
    .brd_we(brd_we), .brd_wdata(brd_wdata),
    .pc_boats_left(pc_boats_left), .player_boats_left(player_boats_left),
    .player_win(player_win), .pc_win(pc_win)
  );

  // Board 1 (PC): id1 @(0,0); id2 @(1,3),(1,4); id3 @(3,0..2); (2,2) already missed.
  // Board 0 (player): id1 @(4,4); id2 @(0,1),(0,2); id3 @(2,2),(3,2),(4,2).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 25; a++)
          mem[b][a] <= 3'd0;
      mem[1][0]  <= 3'd1; mem[1][8]  <= 3'd2; mem[1][9]  <= 3'd2;
      mem[1][15] <= 3'd3; mem[1][16] <= 3'd3; mem[1][17] <= 3'd3;
      mem[1][12] <= 3'd4;
      mem[0][24] <= 3'd1; mem[0][1]  <= 3'd2; mem[0][2]  <= 3'd2;
      mem[0][12] <= 3'd3; mem[0][17] <= 3'd3; mem[0][22] <= 3'd3;
      brd_rdata  <= 3'd0;
    end else begin
      if (brd_re) brd_rdata <= mem[brd_sel][brd_addr];
      if (brd_we) mem[brd_sel][brd_addr] <= brd_wdata;
    end
  end

  // Issues one shot, collects results at the ack; lat is cycles from the sampling edge (-1 on timeout).
  task automatic fire(input bit is_pc, input logic [2:0] r, input logic [2:0] c,
                      output int lat, output logic hit, output logic sunk, output logic rep,
                      output logic inv, output logic winp, output logic [2:0] wd,
                      output int nwe, output int nre);
    bit got = 0;
    lat = 0; nwe = 0; nre = 0; hit = 0; sunk = 0; rep = 0; inv = 0; winp = 0; wd = 0;
    if (is_pc) begin pc_req = 1; pc_row = r; pc_col = c; end
    else begin player_req = 1; player_row = r; player_col = c; end
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (brd_we) begin nwe++; wd = brd_wdata; end
      if (brd_re) nre++;
      if (is_pc ? pc_ack : player_ack) begin
        got = 1; hit = res_hit; sunk = res_sunk; rep = res_repeat; inv = res_invalid;
        winp = player_win;
      end
    end
    player_req = 0; pc_req = 0;
    if (!got) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (player_ack !== 1'b0) begin bad++; $display("FAIL reset_player_ack got=%b exp=0", player_ack); end
    total++; if (brd_re !== 1'b0 || brd_we !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", brd_re, brd_we); end
    total++; if (pc_boats_left !== 3'd3) begin bad++; $display("FAIL reset_pc_boats got=%0d exp=3", pc_boats_left); end
    total++; if (player_boats_left !== 3'd3) begin bad++; $display("FAIL reset_player_boats got=%0d exp=3", player_boats_left); end
    total++; if (player_win !== 1'b0 || pc_win !== 1'b0) begin bad++; $display("FAIL reset_wins got=%b%b exp=00", player_win, pc_win); end
  endtask

  task automatic test_back_to_back();
    int order[4];
    int n = 0;
    int cyc = 0;
    player_req = 1; player_row = 3'd4; player_col = 3'd4;
    pc_req = 1;     pc_row = 3'd1;     pc_col = 3'd1;
    while (n < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (player_ack) begin order[n] = 0; n++; end
      else if (pc_ack) begin order[n] = 1; n++; end
    end
    player_req = 0; pc_req = 0;
    @(posedge clk); #1;
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i < n && order[i] !== (i % 2)) begin
        bad++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, order[i], i % 2);
      end
    end
  endtask

  task automatic test_hit_and_sunk();
    int lat, nwe, nre; logic hit, sunk, rep, inv, winp; logic [2:0] wd;
    fire(0, 3'd1, 3'd3, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (lat !== 4) begin bad++; $display("FAIL hit1_latency got=%0d exp=4", lat); end
    total++; if (hit !== 1'b1 || sunk !== 1'b0) begin bad++; $display("FAIL hit1_flags got=%b%b exp=10", hit, sunk); end
    total++; if (wd !== 3'd6 || nwe !== 1) begin bad++; $display("FAIL hit1_write got=%0d/%0d exp=6/1", wd, nwe); end
    total++; if (pc_boats_left !== 3'd3) begin bad++; $display("FAIL hit1_boats got=%0d exp=3", pc_boats_left); end
    fire(0, 3'd1, 3'd4, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (hit !== 1'b1 || sunk !== 1'b1) begin bad++; $display("FAIL hit2_flags got=%b%b exp=11", hit, sunk); end
    total++; if (pc_boats_left !== 3'd2) begin bad++; $display("FAIL hit2_boats got=%0d exp=2", pc_boats_left); end
    fire(1, 3'd4, 3'd4, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (hit !== 1'b1 || sunk !== 1'b1 || wd !== 3'd5) begin bad++; $display("FAIL pc_hit got=%b%b wd=%0d exp=11 wd=5", hit, sunk, wd); end
    total++; if (player_boats_left !== 3'd2) begin bad++; $display("FAIL pc_hit_boats got=%0d exp=2", player_boats_left); end
  endtask

  task automatic test_repeat();
    int lat, nwe, nre; logic hit, sunk, rep, inv, winp; logic [2:0] wd;
    fire(0, 3'd2, 3'd2, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (rep !== 1'b1 || hit !== 1'b0) begin bad++; $display("FAIL repeat_flags got=%b%b exp=10", rep, hit); end
    total++; if (nwe !== 0) begin bad++; $display("FAIL repeat_no_write got=%0d exp=0", nwe); end
    total++; if (lat !== 3) begin bad++; $display("FAIL repeat_latency got=%0d exp=3", lat); end
    fire(0, 3'd1, 3'd3, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (rep !== 1'b1 || nwe !== 0) begin bad++; $display("FAIL repeat_hitcell got=%b/%0d exp=1/0", rep, nwe); end
  endtask

  task automatic test_invalid();
    int lat, nwe, nre; logic hit, sunk, rep, inv, winp; logic [2:0] wd;
    fire(0, 3'd5, 3'd0, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (lat !== 1) begin bad++; $display("FAIL invalid_latency got=%0d exp=1", lat); end
    total++; if (inv !== 1'b1 || nre !== 0) begin bad++; $display("FAIL invalid_row got=%b/%0d exp=1/0", inv, nre); end
    fire(1, 3'd0, 3'd5, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (inv !== 1'b1 || lat !== 1) begin bad++; $display("FAIL invalid_col got=%b/%0d exp=1/1", inv, lat); end
  endtask

  task automatic test_win();
    int lat, nwe, nre; logic hit, sunk, rep, inv, winp; logic [2:0] wd;
    fire(0, 3'd0, 3'd0, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (sunk !== 1'b1 || pc_boats_left !== 3'd1) begin bad++; $display("FAIL win_id1 got=%b/%0d exp=1/1", sunk, pc_boats_left); end
    fire(0, 3'd3, 3'd0, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    fire(0, 3'd3, 3'd1, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (hit !== 1'b1 || sunk !== 1'b0) begin bad++; $display("FAIL win_id3_partial got=%b%b exp=10", hit, sunk); end
    fire(0, 3'd3, 3'd2, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (sunk !== 1'b1 || winp !== 1'b1) begin bad++; $display("FAIL win_at_ack got=%b%b exp=11", sunk, winp); end
    total++; if (pc_boats_left !== 3'd0 || player_win !== 1'b1) begin bad++; $display("FAIL win_level got=%0d/%b exp=0/1", pc_boats_left, player_win); end
    fire(0, 3'd0, 3'd1, lat, hit, sunk, rep, inv, winp, wd, nwe, nre);
    total++; if (inv !== 1'b1 || lat !== 1 || nre !== 0) begin bad++; $display("FAIL win_next_invalid got=%b/%0d/%0d exp=1/1/0", inv, lat, nre); end
    new_game = 1; @(posedge clk); #1; new_game = 0;
    total++; if (player_win !== 1'b0 || pc_boats_left !== 3'd3 || player_boats_left !== 3'd3) begin
      bad++; $display("FAIL new_game_clear got=%b/%0d/%0d exp=0/3/3", player_win, pc_boats_left, player_boats_left);
    end
  endtask

  task automatic test_new_game_abort();
    logic we_before;
    player_req = 1; player_row = 3'd4; player_col = 3'd0;
    repeat (3) begin @(posedge clk); #1; end
    we_before = brd_we;
    new_game = 1; player_req = 0;
    #1;
    total++; if (we_before !== 1'b1) begin bad++; $display("FAIL abort_write_state got=%b exp=1", we_before); end
    total++; if (brd_we !== 1'b0) begin bad++; $display("FAIL abort_we_suppressed got=%b exp=0", brd_we); end
    @(posedge clk); #1; new_game = 0;
    @(posedge clk); #1;
    total++; if (mem[1][20] !== 3'd0 || player_ack !== 1'b0) begin bad++; $display("FAIL abort_no_effect got=%0d/%b exp=0/0", mem[1][20], player_ack); end
  endtask

  initial begin
    rst = 0; new_game = 0;
    player_req = 0; player_row = 0; player_col = 0;
    pc_req = 0; pc_row = 0; pc_col = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_hit_and_sunk();
    test_repeat();
    test_invalid();
    test_win();
    test_new_game_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
